// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types and defaults for the instruction-fetch prefetch queue.
package fetch_prefetch_queue_pkg;

  // One buffered fetch result: the instruction word and the PC it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam int FETCH_DEPTH_DEF   = 4;
  localparam int FETCH_MAX_OUT_DEF = 2;
  localparam int FETCH_ENTRY_W     = $bits(fetch_entry_t);

  // Force a byte address onto a 32-bit instruction boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with clear, simultaneous push/pop and an occupancy count.
// Storage is not reset; only pointers and count are.
module sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pop_eff;
  logic              push_eff;

  // Guard against popping an empty queue or pushing into a full one.
  always_comb begin
    pop_eff  = pop_i && (count_q != '0);
    push_eff = push_i && ((count_q != CW'(DEPTH)) || pop_eff);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  // Pointer and occupancy registers; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail on each accepted push.
  always_ff @(posedge clk) begin
    if (push_eff && !clear_i && !rst) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: keeps up to MAX_OUTSTANDING in-order imem
// requests in flight and buffers returned words with their PC for decode.
// A queue slot is reserved at issue time, so a response never finds the
// queue full. A redirect flushes the queue and turns every in-flight
// request into a word to be discarded on return.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH           = FETCH_DEPTH_DEF,
  parameter int          MAX_OUTSTANDING = FETCH_MAX_OUT_DEF,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     o_imem_req,
  output logic [31:0]              o_imem_addr,
  input  logic                     i_imem_gnt,
  input  logic                     i_imem_rvalid,
  input  logic [31:0]              i_imem_rdata,
  input  logic                     i_flush,
  input  logic [31:0]              i_jump_addr,
  output logic                     o_valid,
  output logic [31:0]              o_inst,
  output logic [31:0]              o_pc,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_err_spurious
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q,  resp_pc_d;
  logic [CW-1:0] outst_q,    outst_d;
  logic [CW-1:0] discard_q,  discard_d;
  logic          err_q,      err_d;

  logic [CW-1:0] live;
  logic [CW:0]   reserved;
  logic          credit_ok;
  logic          room_ok;
  logic          req;
  logic          issue;
  logic          resp;
  logic          drop;
  logic          push;
  logic          pop;

  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic          fifo_valid;
  logic [CW-1:0] fifo_count;

  // Request gating, response classification and queue handshakes.
  always_comb begin
    resp      = i_imem_rvalid && (outst_q != '0);
    drop      = (discard_q != '0);
    live      = outst_q - discard_q;
    reserved  = {1'b0, fifo_count} + {1'b0, live};
    credit_ok = (outst_q < CW'(MAX_OUTSTANDING));
    room_ok   = (reserved < (CW+1)'(DEPTH));
    req       = !rst && !i_flush && credit_ok && room_ok;
    issue     = req && i_imem_gnt;
    push      = resp && !drop && !i_flush;
    pop       = fifo_valid && i_ready && !i_flush;
    push_entry.pc   = resp_pc_q;
    push_entry.inst = i_imem_rdata;
  end

  // Next-state for fetch/response PCs and the outstanding/discard counters.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    err_d      = i_imem_rvalid && (outst_q == '0);
    if (i_flush) begin
      // Everything still in flight after this cycle's response is stale.
      fetch_pc_d = word_align(i_jump_addr);
      resp_pc_d  = word_align(i_jump_addr);
      outst_d    = outst_q - CW'(resp);
      discard_d  = outst_q - CW'(resp);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp) begin
        if (drop) discard_d = discard_q - 1'b1;
        else      resp_pc_d = resp_pc_q + 32'd4;
      end
      outst_d = outst_q + CW'(issue) - CW'(resp);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      err_q      <= err_d;
    end
  end

  sync_fifo #(
    .DATA_W (FETCH_ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .clear_i (i_flush),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign o_imem_req     = req;
  assign o_imem_addr    = fetch_pc_q;
  assign o_valid        = fifo_valid;
  assign o_inst         = fifo_valid ? head_entry.inst : 32'h0;
  assign o_pc           = fifo_valid ? head_entry.pc   : 32'h0;
  assign o_count        = fifo_count;
  assign o_err_spurious = err_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with an instruction-memory model
// and a scoreboard of expected {pc, inst} entries.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RST_PC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        flush;
  logic [31:0] jump;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        ready;
  logic [2:0]  count;
  logic        err;

  fetch_prefetch_queue #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT),
    .RESET_PC        (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .o_imem_req     (req),
    .o_imem_addr    (addr),
    .i_imem_gnt     (gnt),
    .i_imem_rvalid  (rvalid),
    .i_imem_rdata   (rdata),
    .i_flush        (flush),
    .i_jump_addr    (jump),
    .o_valid        (valid),
    .o_inst         (inst),
    .o_pc           (pc),
    .i_ready        (ready),
    .o_count        (count),
    .o_err_spurious (err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit drop; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

  pend_t       pend[$];
  exp_t        sb[$];
  logic [31:0] m_fetch_pc;
  bit          exp_err;
  bit          mem_en;
  bit          force_rv;
  int          ncmp = 0;
  int          nerr = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs were set at the previous negedge.
  task automatic tick();
    int    live;
    bit    exp_req;
    bit    new_err;
    pend_t p;
    exp_t  e;
    rvalid = force_rv || (mem_en && pend.size() > 0);
    rdata  = (pend.size() > 0) ? inst_of(pend[0].addr) : 32'hBAD0_BAD0;
    #1;
    if (rst) begin
      pend.delete();
      sb.delete();
      m_fetch_pc = RST_PC;
      exp_err    = 1'b0;
    end else begin
      chk("valid", valid, sb.size() != 0);
      chk("count", count, sb.size());
      chk("err", err, exp_err);
      live = 0;
      for (int i = 0; i < pend.size(); i++) if (!pend[i].drop) live++;
      exp_req = !flush && (pend.size() < MAX_OUT) && (sb.size() + live < DEPTH);
      chk("req", req, exp_req);
      if (req && gnt) chk("addr", addr, m_fetch_pc);
      if (valid && ready && !flush && sb.size() > 0) begin
        chk("pc", pc, sb[0].pc);
        chk("inst", inst, sb[0].inst);
        void'(sb.pop_front());
      end
      new_err = 1'b0;
      if (rvalid) begin
        if (pend.size() == 0) new_err = 1'b1;
        else begin
          p = pend.pop_front();
          if (!p.drop && !flush) begin
            e.pc   = p.addr;
            e.inst = inst_of(p.addr);
            sb.push_back(e);
          end
        end
      end
      if (flush) begin
        sb.delete();
        for (int i = 0; i < pend.size(); i++) pend[i].drop = 1'b1;
        m_fetch_pc = jump & 32'hFFFF_FFFC;
      end else if (req && gnt) begin
        p.addr = m_fetch_pc;
        p.drop = 1'b0;
        pend.push_back(p);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      exp_err = new_err;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; gnt = 1'b0; flush = 1'b0; jump = 32'h0; ready = 1'b0;
    rvalid = 1'b0; rdata = 32'h0; mem_en = 1'b0; force_rv = 1'b0;
    m_fetch_pc = RST_PC; exp_err = 1'b0;
    @(negedge clk);
    run(3);
    chk("rst_valid", valid, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_addr", addr, RST_PC);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;

    // Streaming with single-cycle memory latency.
    gnt = 1'b1; mem_en = 1'b1; ready = 1'b1;
    chk("first_addr", addr, RST_PC);
    run(2);
    chk("first_valid_lat", valid, 1'b1);
    chk("first_pc", pc, RST_PC);
    run(12);

    // Decode stalls: queue fills, requests stop, then resume.
    ready = 1'b0;
    run(10);
    chk("full_count", count, 3'd4);
    chk("full_req", req, 1'b0);
    ready = 1'b1;
    run(10);

    // Two requests held in flight, then redirect to 0x200.
    mem_en = 1'b0;
    for (int i = 0; i < 10 && pend.size() < 2; i++) tick();
    chk("two_outstanding", pend.size(), 2);
    flush = 1'b1; jump = 32'h0000_0200;
    tick();
    flush = 1'b0;
    chk("flush_addr", addr, 32'h0000_0200);
    chk("flush_valid", valid, 1'b0);
    mem_en = 1'b1;
    for (int i = 0; i < 10 && !valid; i++) tick();
    chk("post_flush_pc", pc, 32'h0000_0200);
    run(6);

    // Misaligned redirect while a pop is requested on a full queue.
    ready = 1'b0;
    run(8);
    ready = 1'b1; flush = 1'b1; jump = 32'h0000_0203;
    tick();
    flush = 1'b0;
    chk("align_addr", addr, 32'h0000_0200);
    chk("flushpop_valid", valid, 1'b0);
    chk("flushpop_count", count, 3'd0);
    run(5);

    // Back-to-back redirects: the last target wins.
    flush = 1'b1; jump = 32'h0000_0300;
    tick();
    jump = 32'h0000_0400;
    tick();
    flush = 1'b0;
    chk("b2b_addr", addr, 32'h0000_0400);
    run(8);

    // Spurious response with nothing outstanding.
    gnt = 1'b0;
    run(6);
    chk("idle_pend", pend.size(), 0);
    ready = 1'b0;
    run(2);
    force_rv = 1'b1;
    tick();
    force_rv = 1'b0;
    chk("spur_pulse", err, 1'b1);
    tick();
    chk("spur_clear", err, 1'b0);
    ready = 1'b1;
    run(4);

    // Reset in the middle of traffic.
    gnt = 1'b1; ready = 1'b0; mem_en = 1'b1;
    run(3);
    mem_en = 1'b0;
    run(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", valid, 1'b0);
    chk("mrst_count", count, 3'd0);
    chk("mrst_addr", addr, RST_PC);
    ready = 1'b1; mem_en = 1'b1;
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
